// File: rtl/cva6_su_ctrl_pkg.sv
// Shared types and constants for the store-unit memory arbiter.
package cva6_su_ctrl_pkg;

  // Page-offset width used for store/load address matching.
  localparam int unsigned OFFSET_W = 12;

  // Default sizing of the arbiter.
  localparam int unsigned DEF_PEND_DEPTH   = 4;
  localparam int unsigned DEF_HI_WATER     = 3;
  localparam int unsigned DEF_STARVE_LIMIT = 8;

  // Memory-port scheduler states.
  typedef enum logic [2:0] {
    IDLE,
    ST_REQ,
    ST_WAIT,
    LD_REQ,
    LD_WAIT
  } arb_state_e;

  // Outcome of one arbitration decision.
  typedef enum logic [1:0] {
    WIN_NONE,
    WIN_STORE,
    WIN_LOAD
  } arb_win_e;

  // Arbitration rule evaluated while the port is idle.
  //   st_cand    : at least one committed store is waiting to drain
  //   ld_req     : a load is requesting the port
  //   page_match : the load offset hits a store in the store unit
  //   urgent     : stores must go first (high water mark or starvation)
  // A load that hits a store while nothing is committed is waiting on an
  // uncommitted store, so it is not eligible.
  function automatic arb_win_e arbitrate(input logic st_cand,
                                         input logic ld_req,
                                         input logic page_match,
                                         input logic urgent);
    logic ld_elig;
    ld_elig = ld_req && !(page_match && !st_cand);
    if (st_cand && (!ld_elig || urgent || (ld_req && page_match))) begin
      return WIN_STORE;
    end else if (ld_elig) begin
      return WIN_LOAD;
    end
    return WIN_NONE;
  endfunction

endpackage

// File: rtl/cva6_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module cva6_sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o,
  output logic             sat_o
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q;

  // Count up until the limit is reached, restart from zero on clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state is updated with non-blocking assignments so every flop in
    // the design samples pre-edge values regardless of block ordering.
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q < LIMIT_V)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;
  assign sat_o   = (count_q >= LIMIT_V);

endmodule

// File: rtl/cva6_su_mem_arbiter.sv
// Shares the single data-memory port between committed-store drain and
// load requests. One transaction is outstanding at a time; stores drain in
// commit order and each drain produces the store_mem_resp_o pulse.
module cva6_su_mem_arbiter
  import cva6_su_ctrl_pkg::*;
#(
  parameter int unsigned PEND_DEPTH   = DEF_PEND_DEPTH,
  parameter int unsigned HI_WATER     = DEF_HI_WATER,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int unsigned CNT_W       = $clog2(PEND_DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                commit_i,
  input  logic                ld_req_i,
  input  logic [OFFSET_W-1:0] ld_offset_i,
  output logic [OFFSET_W-1:0] page_offset_o,
  input  logic                page_match_i,
  output logic                ld_gnt_o,
  output logic                ld_rvalid_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  output logic                store_mem_resp_o,
  output logic [CNT_W-1:0]    pend_cnt_o,
  output logic                error_o
);

  localparam int unsigned      STV_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(PEND_DEPTH);
  localparam logic [CNT_W-1:0] HI_W     = CNT_W'(HI_WATER);

  arb_state_e       state_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [CNT_W-1:0] pend_cnt_q;
  logic             error_q;

  logic [STV_W-1:0] starve_cnt;
  logic             starved;

  logic             in_idle;
  logic             st_cand;
  logic             urgent;
  arb_win_e         win;
  logic             st_win;
  logic             ld_win;
  logic             drain;
  logic             pend_full;
  logic             overflow;
  logic             spurious_rvalid;

  // The store unit compares the load offset against its queue directly.
  assign page_offset_o = ld_offset_i;

  // Arbitration inputs; the decision only takes effect in IDLE.
  assign in_idle = (state_q == IDLE);
  assign st_cand = (pend_cnt_q != '0);
  assign urgent  = (pend_cnt_q >= HI_W) || starved;
  assign win     = arbitrate(st_cand, ld_req_i, page_match_i, urgent);
  assign st_win  = in_idle && (win == WIN_STORE);
  assign ld_win  = in_idle && (win == WIN_LOAD);

  // Handshake pulses are decoded from the current state and memory inputs.
  assign ld_gnt_o         = (state_q == LD_REQ)  && mem_gnt_i;
  assign ld_rvalid_o      = (state_q == LD_WAIT) && mem_rvalid_i;
  assign store_mem_resp_o = (state_q == ST_WAIT) && mem_rvalid_i;

  assign mem_req_o = mem_req_q;
  assign mem_we_o  = mem_we_q;

  // A response with nothing granted and waiting cannot belong to us.
  assign spurious_rvalid = mem_rvalid_i &&
                           ((state_q == IDLE) || (state_q == ST_REQ) || (state_q == LD_REQ));

  // Scheduler FSM; request and write-enable are registered with the state so
  // they leave the block glitch-free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (st_win) begin
            state_q   <= ST_REQ;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
          end else if (ld_win) begin
            state_q   <= LD_REQ;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) begin
            state_q   <= ST_WAIT;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        LD_REQ: begin
          if (mem_gnt_i) begin
            state_q   <= LD_WAIT;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid_i) begin
            state_q <= IDLE;
          end
        end
        LD_WAIT: begin
          if (mem_rvalid_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  // Pending-store bookkeeping: a commit into a full tracker is dropped.
  assign drain     = store_mem_resp_o;
  assign pend_full = (pend_cnt_q == PEND_MAX);
  assign overflow  = commit_i && !drain && pend_full;

  // Committed-but-undrained store count; commit and drain together cancel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_cnt_q <= '0;
    end else if (commit_i && !drain && !pend_full) begin
      pend_cnt_q <= pend_cnt_q + 1'b1;
    end else if (drain && !commit_i) begin
      pend_cnt_q <= pend_cnt_q - 1'b1;
    end
  end

  assign pend_cnt_o = pend_cnt_q;

  // Sticky error flag for tracker overflow and unexpected responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      error_q <= 1'b0;
    end else if (overflow || spurious_rvalid) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;

  // Loads granted ahead of waiting stores; forces a store once saturated.
  cva6_sat_counter #(
    .WIDTH (STV_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (ld_win && st_cand),
    .clear_i (st_win),
    .count_o (starve_cnt),
    .sat_o   (starved)
  );

endmodule

// File: tb/tb_cva6_su_mem_arbiter.sv
// Self-checking bench for cva6_su_mem_arbiter: directed scenarios with
// literal expectations plus a randomized run against a transaction-level
// reference model that is compared with the DUT on every cycle.
module tb_cva6_su_mem_arbiter;

  localparam int PEND_DEPTH   = 4;
  localparam int HI_WATER     = 3;
  localparam int STARVE_LIMIT = 8;

  localparam int K_NONE  = 0;
  localparam int K_STORE = 1;
  localparam int K_LOAD  = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        commit_i = 1'b0;
  logic        ld_req_i = 1'b0;
  logic [11:0] ld_offset_i = '0;
  logic [11:0] page_offset_o;
  logic        page_match_i = 1'b0;
  logic        ld_gnt_o;
  logic        ld_rvalid_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic        store_mem_resp_o;
  logic [2:0]  pend_cnt_o;
  logic        error_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding transaction kind and whether it is granted.
  int m_kind    = K_NONE;
  bit m_granted = 1'b0;
  int m_pend    = 0;
  int m_starve  = 0;
  bit m_err     = 1'b0;

  // Driver-side observations and automatic memory responder.
  bit auto_mem = 1'b0;
  bit gnt_seen, rsp_seen, rv_next;

  cva6_su_mem_arbiter dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .commit_i         (commit_i),
    .ld_req_i         (ld_req_i),
    .ld_offset_i      (ld_offset_i),
    .page_offset_o    (page_offset_o),
    .page_match_i     (page_match_i),
    .ld_gnt_o         (ld_gnt_o),
    .ld_rvalid_o      (ld_rvalid_o),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .mem_gnt_i        (mem_gnt_i),
    .mem_rvalid_i     (mem_rvalid_i),
    .store_mem_resp_o (store_mem_resp_o),
    .pend_cnt_o       (pend_cnt_o),
    .error_o          (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Who gets the idle port, straight from the scheduling rules.
  function automatic int decide(int pend, int starve, bit req, bit match);
    bit store_ok, load_ok;
    store_ok = (pend > 0);
    load_ok  = req && !(match && pend == 0);
    if (store_ok && (!load_ok || pend >= HI_WATER || starve >= STARVE_LIMIT || (req && match)))
      return K_STORE;
    if (load_ok)
      return K_LOAD;
    return K_NONE;
  endfunction

  // Advance the reference model at each clock edge.
  always @(posedge clk_i or negedge rst_ni) begin
    int who;
    bit waiting, drain;
    if (!rst_ni) begin
      m_kind = K_NONE; m_granted = 0; m_pend = 0; m_starve = 0; m_err = 0;
    end else begin
      waiting = (m_kind != K_NONE) && m_granted;
      drain   = (m_kind == K_STORE) && m_granted && mem_rvalid_i;
      if (mem_rvalid_i && !waiting) m_err = 1;
      if (m_kind == K_NONE) begin
        who = decide(m_pend, m_starve, ld_req_i, page_match_i);
        if (who == K_STORE) begin
          m_kind = K_STORE; m_granted = 0; m_starve = 0;
        end else if (who == K_LOAD) begin
          m_kind = K_LOAD; m_granted = 0;
          if (m_pend > 0 && m_starve < STARVE_LIMIT) m_starve++;
        end
      end else if (!m_granted) begin
        if (mem_gnt_i) m_granted = 1;
      end else if (mem_rvalid_i) begin
        m_kind = K_NONE; m_granted = 0;
      end
      if (commit_i && !drain && m_pend == PEND_DEPTH) m_err = 1;
      else m_pend = m_pend + int'(commit_i) - int'(drain);
    end
  end

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk_i) begin
    check("mem_req",    mem_req_o,        (m_kind != K_NONE) && !m_granted);
    check("mem_we",     mem_we_o,         (m_kind == K_STORE) && !m_granted);
    check("ld_gnt",     ld_gnt_o,         (m_kind == K_LOAD) && !m_granted && mem_gnt_i);
    check("ld_rvalid",  ld_rvalid_o,      (m_kind == K_LOAD) && m_granted && mem_rvalid_i);
    check("store_resp", store_mem_resp_o, (m_kind == K_STORE) && m_granted && mem_rvalid_i);
    check("pend_cnt",   pend_cnt_o,       m_pend);
    check("error",      error_o,          m_err);
    check("page_offset", page_offset_o,   ld_offset_i);
  end

  // One clock: sample outputs at the falling edge, then drive at rise + 1.
  task automatic step();
    @(negedge clk_i);
    gnt_seen = ld_gnt_o;
    rsp_seen = store_mem_resp_o;
    rv_next  = mem_req_o && mem_gnt_i;
    @(posedge clk_i);
    #1;
    if (auto_mem) begin
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = rv_next;
    end
  endtask

  task automatic apply_reset();
    rst_ni = 0; auto_mem = 0;
    commit_i = 0; ld_req_i = 0; page_match_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    repeat (2) step();
    rst_ni = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ld, n_rsp;
    bit got;

    // Reset, then idle.
    apply_reset();
    repeat (5) step();
    #2;
    check("rst_mem_req",   mem_req_o, 1'b0);
    check("rst_mem_we",    mem_we_o, 1'b0);
    check("rst_ld_gnt",    ld_gnt_o, 1'b0);
    check("rst_ld_rvalid", ld_rvalid_o, 1'b0);
    check("rst_resp",      store_mem_resp_o, 1'b0);
    check("rst_pend",      pend_cnt_o, 3'd0);
    check("rst_error",     error_o, 1'b0);

    // Minimum store drain latency.
    commit_i = 1; step(); commit_i = 0;
    #2 check("drain_t1_pend", pend_cnt_o, 3'd1);
    check("drain_t1_req", mem_req_o, 1'b0);
    step(); mem_gnt_i = 1;
    #2 check("drain_t2_req", mem_req_o, 1'b1);
    check("drain_t2_we", mem_we_o, 1'b1);
    step(); mem_gnt_i = 0; mem_rvalid_i = 1;
    #2 check("drain_t3_resp", store_mem_resp_o, 1'b1);
    step(); mem_rvalid_i = 0;
    #2 check("drain_t4_pend", pend_cnt_o, 3'd0);
    check("drain_t4_req", mem_req_o, 1'b0);

    // Starvation: one pending store behind a continuous load stream.
    auto_mem = 1; mem_gnt_i = 1;
    commit_i = 1; step(); commit_i = 0;
    ld_req_i = 1; ld_offset_i = 12'h123;
    n_ld = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      step();
      if (rsp_seen) got = 1;
      else if (gnt_seen) n_ld++;
    end
    check("starve_store_done", got, 1'b1);
    check("starve_loads", n_ld, 8);
    #2 check("starve_cleared", dut.starve_cnt, 0);
    for (int i = 0; i < 20 && ld_req_i; i++) begin
      step();
      if (gnt_seen) ld_req_i = 0;
    end
    check("starve_ld_drop", ld_req_i, 1'b0);
    repeat (3) step();

    // Load hitting an uncommitted store waits; the store goes first once committed.
    ld_req_i = 1; page_match_i = 1; ld_offset_i = 12'hABC;
    #2 check("fwd_offset", page_offset_o, 12'hABC);
    for (int i = 0; i < 10; i++) begin
      step();
      #2 check("blocked_noreq", mem_req_o, 1'b0);
    end
    commit_i = 1; step(); commit_i = 0;
    n_ld = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (rsp_seen) got = 1;
      else if (gnt_seen) n_ld++;
    end
    check("hit_store_first", got, 1'b1);
    repeat (5) begin
      step();
      if (gnt_seen) n_ld++;
    end
    check("hit_load_held", n_ld, 0);
    page_match_i = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (gnt_seen) got = 1;
    end
    check("hit_load_after", got, 1'b1);
    ld_req_i = 0;
    repeat (3) step();

    // Overflow of the pending tracker with the memory stalled.
    apply_reset();
    commit_i = 1; repeat (5) step(); commit_i = 0;
    #2 check("ovf_pend", pend_cnt_o, 3'd4);
    check("ovf_error", error_o, 1'b1);

    // Commit and drain together at full occupancy.
    apply_reset();
    commit_i = 1; repeat (4) step(); commit_i = 0;
    #2 check("full_pend", pend_cnt_o, 3'd4);
    check("full_error", error_o, 1'b0);
    mem_gnt_i = 1; step(); mem_gnt_i = 0;
    mem_rvalid_i = 1; commit_i = 1;
    #2 check("full_drain_resp", store_mem_resp_o, 1'b1);
    step(); mem_rvalid_i = 0; commit_i = 0;
    #2 check("full_both_pend", pend_cnt_o, 3'd4);
    check("full_both_error", error_o, 1'b0);

    // Spurious response while idle.
    apply_reset();
    mem_rvalid_i = 1; step(); mem_rvalid_i = 0;
    #2 check("spur_error", error_o, 1'b1);
    check("spur_pend", pend_cnt_o, 3'd0);

    // Reset while a store waits for its response.
    apply_reset();
    commit_i = 1; step(); commit_i = 0; mem_gnt_i = 1;
    step(); step(); mem_gnt_i = 0;
    #2 rst_ni = 0; mem_rvalid_i = 1;
    #1 check("rstw_resp", store_mem_resp_o, 1'b0);
    n_rsp = 0;
    repeat (3) begin step(); if (rsp_seen) n_rsp++; end
    rst_ni = 1; mem_rvalid_i = 0;
    repeat (3) begin step(); if (rsp_seen) n_rsp++; end
    check("rstw_no_pulse", n_rsp, 0);
    check("rstw_pend", pend_cnt_o, 3'd0);

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i % 1000 == 500) apply_reset();
      commit_i = ($urandom_range(0, 5) == 0);
      if (ld_req_i && gnt_seen) ld_req_i = 0;
      else if (!ld_req_i && $urandom_range(0, 2) == 0) begin
        ld_req_i    = 1;
        ld_offset_i = 12'($urandom);
      end
      page_match_i = ($urandom_range(0, 3) == 0);
      mem_gnt_i    = 1'($urandom_range(0, 1));
      if (m_kind != K_NONE && m_granted) mem_rvalid_i = 1'($urandom_range(0, 1));
      else mem_rvalid_i = ($urandom_range(0, 299) == 0);
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cva6_su_mem_arbiter.md
# cva6_su_mem_arbiter

Scheduler that shares the single data-memory port between store-buffer drain and load requests in the CVA6 store-unit verification model. It counts committed-but-undrained stores, issues their memory writes in order, and generates the `store_mem_resp_i` pulse consumed by `cva6_su_model`. It also arbitrates loads, stalling any load whose page offset hits a pending store. At most one memory transaction is outstanding.

## Interface
Parameters:
- `PEND_DEPTH`, 4: max committed stores tracked; matches the store queue depth.
- `HI_WATER`, 3: pending count at which stores beat loads unconditionally.
- `STARVE_LIMIT`, 8: load grants allowed while stores wait before stores are forced.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `commit_i` in 1: one store committed this cycle.
- `ld_req_i` in 1: load request, level, held until `ld_gnt_o`.
- `ld_offset_i` in 12: load page offset.
- `page_offset_o` out 12: `ld_offset_i` forwarded to store unit `page_offset_i`, combinational.
- `page_match_i` in 1: store unit `page_offset_matches_o`.
- `ld_gnt_o` out 1: load accepted by memory, 1-cycle pulse.
- `ld_rvalid_o` out 1: load data returned, 1-cycle pulse.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: 1 = store, 0 = load; valid while `mem_req_o`.
- `mem_gnt_i` in 1: memory accepts request.
- `mem_rvalid_i` in 1: memory response for the outstanding transaction.
- `store_mem_resp_o` out 1: store drained, 1-cycle pulse to store unit.
- `pend_cnt_o` out $clog2(PEND_DEPTH+1): committed, undrained stores.
- `error_o` out 1: sticky; set on commit overflow or spurious `mem_rvalid_i`.

## Operation
- FSM states: IDLE, ST_REQ, ST_WAIT, LD_REQ, LD_WAIT.
- `mem_req_o` = state ∈ {ST_REQ, LD_REQ}; `mem_we_o` = (state == ST_REQ).
- **IDLE:**
  - store candidate = `pend_cnt > 0`.
  - load eligible = `ld_req_i && !(page_match_i && pend_cnt == 0)`. An offset hit with no committed store means the matching store is uncommitted, so the load waits.
  - Store wins if it is a candidate and any of these holds: load not eligible; `pend_cnt >= HI_WATER`; `starve_cnt >= STARVE_LIMIT`; `ld_req_i && page_match_i`. Otherwise an eligible load wins. With neither, stay in IDLE.
- **ST_REQ / LD_REQ:**
  - Hold the request until `mem_gnt_i`, then go to ST_WAIT / LD_WAIT.
  - `ld_gnt_o` = LD_REQ && `mem_gnt_i`.
- **ST_WAIT:** on `mem_rvalid_i`, pulse `store_mem_resp_o` in the same cycle and return to IDLE.
- **LD_WAIT:** on `mem_rvalid_i`, pulse `ld_rvalid_o` in the same cycle and return to IDLE.
- **pend_cnt:**
  - +1 on `commit_i`; −1 on `store_mem_resp_o`; both in one cycle → unchanged.
  - `commit_i` at `PEND_DEPTH` with no simultaneous drain → ignored, `error_o` set.
- **starve_cnt:**
  - +1, saturating at `STARVE_LIMIT`, each time a load wins while `pend_cnt > 0`.
  - Cleared when a store wins.
- `mem_rvalid_i` in IDLE, ST_REQ or LD_REQ → ignored, `error_o` set.

## Timing
- Reset: state IDLE, `pend_cnt`/`starve_cnt` = 0, `error_o` = 0.
- All outputs 0 during and after reset, except `page_offset_o`, which follows `ld_offset_i`.
- A reset mid-transaction abandons the transaction; no response pulse is emitted.
- Arbitration decision in IDLE at cycle t → `mem_req_o` at t+1.
- Minimum store drain: `commit_i` at t, `pend_cnt_o` = 1 at t+1, `mem_req_o` at t+2, `mem_gnt_i` at t+2, `mem_rvalid_i` at t+3 gives `store_mem_resp_o` at t+3 and `pend_cnt_o` = 0 at t+4.
- Back-to-back transactions: IDLE costs exactly one cycle between them.
- `ld_gnt_o`, `ld_rvalid_o` and `store_mem_resp_o` are combinational from memory inputs and state. No input→output loop exists except `page_offset_o`.

## Structure
- Package `cva6_su_ctrl_pkg`:
  - FSM state enum.
  - Default parameter constants.
  - Offset width constant (12).
- Sub-module `cva6_sat_counter` (parameterised width/limit, inc/clear, saturating) for `starve_cnt`.
- The pending counter stays inline because it has inc, dec and overflow detection.

## Test plan
- Reset then idle 5 cycles → all outputs 0, `pend_cnt_o` = 0.
- `commit_i` at t=0, `mem_gnt_i` on first request, `mem_rvalid_i` one cycle later → `mem_req_o` and `mem_we_o` at t=2, `store_mem_resp_o` at t=3, `pend_cnt_o` = 0 at t=4.
- `pend_cnt` = 1, continuous `ld_req_i`, `page_match_i` = 0, memory always grants and responds next cycle → 8 load grants then one store drain; `starve_cnt` cleared afterwards.
- `ld_req_i` with `page_match_i` = 1 and `pend_cnt` = 0 → no `mem_req_o` for 10 cycles. Then `commit_i` → store drains first, then the load once `page_match_i` drops.
- Five `commit_i` with `mem_gnt_i` held low → `pend_cnt_o` = 4, `error_o` = 1 after the fifth. Simultaneous commit and drain at `pend_cnt` = 4 → count stays 4, no error.
- `mem_rvalid_i` in IDLE → `error_o` = 1, `pend_cnt_o` unchanged. Assert `rst_ni` low in ST_WAIT → IDLE, `store_mem_resp_o` never pulses.
